// File: rtl/prio_dispatch_scheduler_pkg.sv
// Shared constants, dispatch-mode encodings and FSM state type for the
// per-output-port dispatch scheduler.
package prio_dispatch_scheduler_pkg;

   localparam int unsigned PORT_NUB_TOTAL = 16;
   localparam int unsigned PRIORITY       = 8;
   localparam int unsigned WIDTH_PRIORITY = $clog2(PRIORITY);
   localparam int unsigned WIDTH_WIEGHT   = $clog2(PRIORITY);

   localparam logic DISPATCH_SP  = 1'b0;
   localparam logic DISPATCH_WRR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_GRANT  = 2'd2
   } sched_state_e;

endpackage

// File: rtl/prio_dispatch_scheduler_rr_prio_picker.sv
// Combinational first-set finder: scans req upward from ptr with wrap
// and reports whether anything was found and at which index.
module rr_prio_picker #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found_c,
   output logic [W-1:0] idx_c
);

   logic [W-1:0] cand;

   // N is a power of two, so W-bit addition wraps modulo N
   always_comb begin
      found_c = 1'b0;
      idx_c   = '0;
      cand    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = W'(ptr + W'(i));
         if (!found_c && req[cand]) begin
            found_c = 1'b1;
            idx_c   = cand;
         end
      end
   end

endmodule

// File: rtl/prio_dispatch_scheduler.sv
// Per-output-port read-side scheduler: strict-priority or weighted round
// robin selection of a priority queue, held for one whole packet.
module prio_dispatch_scheduler
   import prio_dispatch_scheduler_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             dispatch_sel,
   input  logic [PRIORITY*WIDTH_WIEGHT-1:0] wrr_wieght_in,
   input  logic [PRIORITY-1:0]              queue_nempty,
   input  logic                             ready,
   input  logic                             pkt_done,
   output logic                             grant_vld,
   output logic [WIDTH_PRIORITY-1:0]        grant_sel,
   output logic [PRIORITY-1:0]              grant_onehot,
   output logic                             busy
);

   sched_state_e                state_q, state_d;
   logic                        grant_vld_q, grant_vld_d;
   logic [WIDTH_PRIORITY-1:0]   grant_sel_q, grant_sel_d;
   logic [PRIORITY-1:0]         grant_onehot_q, grant_onehot_d;
   logic                        busy_q, busy_d;
   logic [WIDTH_WIEGHT-1:0]     credit_q [PRIORITY];
   logic [WIDTH_WIEGHT-1:0]     credit_d [PRIORITY];
   logic [WIDTH_PRIORITY-1:0]   rr_ptr_q, rr_ptr_d;

   logic [PRIORITY-1:0]         weight_nz_c;
   logic [PRIORITY-1:0]         eligible_c;
   logic                        sp_found_c, wrr_found_c;
   logic [WIDTH_PRIORITY-1:0]   sp_idx_c, wrr_idx_c;
   logic                        take_c;
   logic [WIDTH_PRIORITY-1:0]   take_idx_c;

   always_comb begin
      for (int unsigned q = 0; q < PRIORITY; q++) begin
         weight_nz_c[q] = |wrr_wieght_in[q*WIDTH_WIEGHT +: WIDTH_WIEGHT];
         eligible_c[q]  = queue_nempty[q] & (credit_q[q] != '0);
      end
   end

   rr_prio_picker #(.N(PRIORITY), .W(WIDTH_PRIORITY)) u_sp_pick (
      .req     (queue_nempty),
      .ptr     ('0),
      .found_c (sp_found_c),
      .idx_c   (sp_idx_c)
   );

   rr_prio_picker #(.N(PRIORITY), .W(WIDTH_PRIORITY)) u_wrr_pick (
      .req     (eligible_c),
      .ptr     (rr_ptr_q),
      .found_c (wrr_found_c),
      .idx_c   (wrr_idx_c)
   );

   // Next-state, grant and credit bookkeeping
   always_comb begin
      state_d        = state_q;
      grant_vld_d    = grant_vld_q;
      grant_sel_d    = grant_sel_q;
      grant_onehot_d = grant_onehot_q;
      credit_d       = credit_q;
      rr_ptr_d       = rr_ptr_q;
      take_c         = 1'b0;
      take_idx_c     = '0;

      case (state_q)
         ST_IDLE: begin
            if (ready) begin
               if (dispatch_sel == DISPATCH_WRR && wrr_found_c) begin
                  take_c     = 1'b1;
                  take_idx_c = wrr_idx_c;
                  credit_d[wrr_idx_c] = credit_q[wrr_idx_c] - WIDTH_WIEGHT'(1);
                  // pointer parks on the queue until its last credit is spent
                  rr_ptr_d = (credit_q[wrr_idx_c] == WIDTH_WIEGHT'(1)) ?
                             WIDTH_PRIORITY'(wrr_idx_c + WIDTH_PRIORITY'(1)) : wrr_idx_c;
               end else if (dispatch_sel == DISPATCH_WRR && |(queue_nempty & weight_nz_c)) begin
                  state_d = ST_REFILL;
               end else if (sp_found_c) begin
                  take_c     = 1'b1;
                  take_idx_c = sp_idx_c;
               end
            end
            if (take_c) begin
               state_d        = ST_GRANT;
               grant_vld_d    = 1'b1;
               grant_sel_d    = take_idx_c;
               grant_onehot_d = PRIORITY'(1) << take_idx_c;
            end
         end
         ST_REFILL: begin
            for (int unsigned q = 0; q < PRIORITY; q++) begin
               credit_d[q] = wrr_wieght_in[q*WIDTH_WIEGHT +: WIDTH_WIEGHT];
            end
            state_d = ST_IDLE;
         end
         ST_GRANT: begin
            if (pkt_done) begin
               state_d        = ST_IDLE;
               grant_vld_d    = 1'b0;
               grant_onehot_d = '0;
            end
         end
         default: begin
            state_d        = ST_IDLE;
            grant_vld_d    = 1'b0;
            grant_onehot_d = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         grant_vld_q    <= 1'b0;
         grant_sel_q    <= '0;
         grant_onehot_q <= '0;
         busy_q         <= 1'b0;
         credit_q       <= '{default: '0};
         rr_ptr_q       <= '0;
      end else begin
         state_q        <= state_d;
         grant_vld_q    <= grant_vld_d;
         grant_sel_q    <= grant_sel_d;
         grant_onehot_q <= grant_onehot_d;
         busy_q         <= busy_d;
         credit_q       <= credit_d;
         rr_ptr_q       <= rr_ptr_d;
      end
   end

   assign grant_vld    = grant_vld_q;
   assign grant_sel    = grant_sel_q;
   assign grant_onehot = grant_onehot_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_prio_dispatch_scheduler.sv
// Bench for prio_dispatch_scheduler: directed scenarios plus randomized
// traffic compared cycle by cycle with a behavioural reference model.
module tb_prio_dispatch_scheduler;

   localparam int NQ = 8;
   localparam int WW = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           dispatch_sel;
   logic [NQ*WW-1:0] wrr_wieght_in;
   logic [NQ-1:0]  queue_nempty;
   logic           ready;
   logic           pkt_done;
   logic           grant_vld;
   logic [WW-1:0]  grant_sel;
   logic [NQ-1:0]  grant_onehot;
   logic           busy;

   int checks = 0;
   int errors = 0;

   // reference model: phase 0 idle, 1 refill, 2 serving a packet
   int m_phase;
   int m_sel;
   int m_ptr;
   int m_credit [NQ];
   bit m_vld;

   prio_dispatch_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .dispatch_sel  (dispatch_sel),
      .wrr_wieght_in (wrr_wieght_in),
      .queue_nempty  (queue_nempty),
      .ready         (ready),
      .pkt_done      (pkt_done),
      .grant_vld     (grant_vld),
      .grant_sel     (grant_sel),
      .grant_onehot  (grant_onehot),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   function automatic int weight_of(int q);
      return int'((wrr_wieght_in >> (q * WW)) & 24'd7);
   endfunction

   function automatic void model_grant(int q);
      m_phase = 2;
      m_vld   = 1'b1;
      m_sel   = q;
   endfunction

   function automatic void model_update();
      int pick;
      bit want_refill;
      pick = -1;
      want_refill = 1'b0;
      if (rst) begin
         m_phase = 0; m_vld = 1'b0; m_sel = 0; m_ptr = 0;
         for (int q = 0; q < NQ; q++) m_credit[q] = 0;
         return;
      end
      if (m_phase == 1) begin
         for (int q = 0; q < NQ; q++) m_credit[q] = weight_of(q);
         m_phase = 0;
      end else if (m_phase == 2) begin
         if (pkt_done) begin
            m_phase = 0;
            m_vld   = 1'b0;
         end
      end else if (ready) begin
         if (dispatch_sel) begin
            for (int k = 0; k < NQ; k++) begin
               int q;
               q = (m_ptr + k) % NQ;
               if (pick < 0 && queue_nempty[q] && m_credit[q] > 0) pick = q;
            end
            if (pick >= 0) begin
               m_credit[pick] = m_credit[pick] - 1;
               m_ptr = (m_credit[pick] == 0) ? (pick + 1) % NQ : pick;
               model_grant(pick);
               return;
            end
            for (int q = 0; q < NQ; q++)
               if (queue_nempty[q] && weight_of(q) > 0) want_refill = 1'b1;
            if (want_refill) begin
               m_phase = 1;
               return;
            end
         end
         for (int q = 0; q < NQ; q++)
            if (pick < 0 && queue_nempty[q]) pick = q;
         if (pick >= 0) model_grant(pick);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; dispatch_sel = 1'b0; wrr_wieght_in = '0;
      queue_nempty = '0; ready = 1'b0; pkt_done = 1'b0;
      tick(); tick();
      rst = 1'b0;
      checks++; if (grant_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0d expected 0", grant_vld); end
      checks++; if (grant_sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", grant_sel); end
      checks++; if (grant_onehot !== 8'h00) begin errors++; $display("FAIL reset_onehot: got %h expected 00", grant_onehot); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy); end
   endtask

   task automatic test_strict();
      do_reset();
      dispatch_sel = 1'b0; queue_nempty = 8'b1010_0100; ready = 1'b1;
      tick();
      checks++; if (grant_vld !== 1'b1) begin errors++; $display("FAIL sp_vld: got %0d expected 1", grant_vld); end
      checks++; if (grant_sel !== 3'd2) begin errors++; $display("FAIL sp_sel: got %0d expected 2", grant_sel); end
      checks++; if (grant_onehot !== 8'h04) begin errors++; $display("FAIL sp_onehot: got %h expected 04", grant_onehot); end
      // inputs other than pkt_done are ignored while serving
      queue_nempty = 8'hFF; ready = 1'b0; dispatch_sel = 1'b1;
      tick(); tick();
      checks++; if (grant_sel !== 3'd2 || grant_vld !== 1'b1) begin errors++; $display("FAIL sp_hold: got sel %0d vld %0d expected sel 2 vld 1", grant_sel, grant_vld); end
      dispatch_sel = 1'b0; ready = 1'b1; queue_nempty = 8'b1010_0000; pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
      checks++; if (grant_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sp_release: got vld %0d busy %0d expected 0 0", grant_vld, busy); end
      tick();
      checks++; if (grant_sel !== 3'd5 || grant_vld !== 1'b1) begin errors++; $display("FAIL sp_next: got sel %0d vld %0d expected sel 5 vld 1", grant_sel, grant_vld); end
      pkt_done = 1'b1; tick(); pkt_done = 1'b0;
   endtask

   task automatic test_wrr_ratio();
      int refills;
      int budget;
      int exp_sel;
      refills = 0;
      do_reset();
      dispatch_sel = 1'b1; wrr_wieght_in = 24'd3 | (24'd1 << 3);
      queue_nempty = 8'h03; ready = 1'b1;
      for (int g = 0; g < 40; g++) begin
         budget = 0;
         while (!grant_vld && budget < 20) begin
            tick();
            if (busy && !grant_vld) refills++;
            budget++;
         end
         checks++;
         if (!grant_vld) begin errors++; $display("FAIL wrr_timeout: grant %0d never came", g); return; end
         exp_sel = (g % 4 == 3) ? 1 : 0;
         checks++; if (grant_sel !== WW'(exp_sel)) begin errors++; $display("FAIL wrr_seq[%0d]: got %0d expected %0d", g, grant_sel, exp_sel); end
         repeat (3) tick();
         pkt_done = 1'b1; tick(); pkt_done = 1'b0;
      end
      checks++; if (refills != 10) begin errors++; $display("FAIL wrr_refills: got %0d expected 10", refills); end
      ready = 1'b0;
   endtask

   task automatic test_zero_weights();
      do_reset();
      dispatch_sel = 1'b1; wrr_wieght_in = '0; queue_nempty = 8'b0001_1000; ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         tick();
         checks++; if (grant_vld !== 1'b1 || grant_sel !== 3'd3) begin errors++; $display("FAIL zw_grant[%0d]: got vld %0d sel %0d expected vld 1 sel 3", r, grant_vld, grant_sel); end
         pkt_done = 1'b1; tick(); pkt_done = 1'b0;
         checks++; if (busy !== 1'b0 || grant_vld !== 1'b0) begin errors++; $display("FAIL zw_idle[%0d]: got busy %0d vld %0d expected 0 0", r, busy, grant_vld); end
      end
      ready = 1'b0;
   endtask

   task automatic test_wrap();
      int exp_seq [10];
      int refills;
      int budget;
      exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
      do_reset();
      dispatch_sel = 1'b1; wrr_wieght_in = '0;
      for (int q = 0; q < NQ; q++) wrr_wieght_in[q*WW +: WW] = 3'd1;
      queue_nempty = 8'hFF; ready = 1'b1;
      for (int g = 0; g < 10; g++) begin
         refills = 0; budget = 0;
         while (!grant_vld && budget < 20) begin
            tick();
            if (busy && !grant_vld) refills++;
            budget++;
         end
         checks++;
         if (!grant_vld) begin errors++; $display("FAIL wrap_timeout: grant %0d never came", g); return; end
         checks++; if (grant_sel !== WW'(exp_seq[g])) begin errors++; $display("FAIL wrap_seq[%0d]: got %0d expected %0d", g, grant_sel, exp_seq[g]); end
         checks++; if (refills != ((g == 0 || g == 8) ? 1 : 0)) begin errors++; $display("FAIL wrap_refill[%0d]: got %0d expected %0d", g, refills, (g == 0 || g == 8) ? 1 : 0); end
         pkt_done = 1'b1; tick(); pkt_done = 1'b0;
      end
      ready = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      dispatch_sel = 1'b0; queue_nempty = 8'h30; ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pkt_done = (i % 2 == 0);
         tick();
         checks++; if (grant_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got vld %0d busy %0d expected 0 0", i, grant_vld, busy); end
      end
      pkt_done = 1'b0; ready = 1'b1;
      tick();
      checks++; if (grant_vld !== 1'b1 || grant_sel !== 3'd4) begin errors++; $display("FAIL bp_grant: got vld %0d sel %0d expected vld 1 sel 4", grant_vld, grant_sel); end
      pkt_done = 1'b1; tick(); pkt_done = 1'b0;
      ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      dispatch_sel = 1'b0; queue_nempty = 8'h81; ready = 1'b1;
      for (int q = 0; q < NQ; q++) wrr_wieght_in[q*WW +: WW] = 3'd2;
      tick();
      checks++; if (grant_vld !== 1'b1) begin errors++; $display("FAIL rm_pre: got vld %0d expected 1", grant_vld); end
      dispatch_sel = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (grant_vld !== 1'b0 || busy !== 1'b0 || grant_onehot !== 8'h00) begin errors++; $display("FAIL rm_clear: got vld %0d busy %0d oh %h expected 0 0 00", grant_vld, busy, grant_onehot); end
      tick();
      checks++; if (busy !== 1'b1 || grant_vld !== 1'b0) begin errors++; $display("FAIL rm_refill: got busy %0d vld %0d expected 1 0", busy, grant_vld); end
      tick();
      checks++; if (busy !== 1'b0 || grant_vld !== 1'b0) begin errors++; $display("FAIL rm_idle: got busy %0d vld %0d expected 0 0", busy, grant_vld); end
      tick();
      checks++; if (grant_vld !== 1'b1 || grant_sel !== 3'd0) begin errors++; $display("FAIL rm_grant: got vld %0d sel %0d expected 1 0", grant_vld, grant_sel); end
      pkt_done = 1'b1; tick(); pkt_done = 1'b0;
      ready = 1'b0;
   endtask

   task automatic test_random();
      logic [NQ-1:0] exp_oh;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 40 == 0) begin
            for (int q = 0; q < NQ; q++)
               wrr_wieght_in[q*WW +: WW] = ($urandom % 4 == 0) ? 3'd0 : WW'($urandom % 8);
         end
         if (c % 200 == 0) dispatch_sel = 1'($urandom % 2);
         else if ($urandom % 50 == 0) dispatch_sel = ~dispatch_sel;
         queue_nempty = ($urandom % 8 == 0) ? 8'h00 : NQ'($urandom & $urandom);
         ready    = ($urandom % 4 != 0);
         pkt_done = grant_vld ? ($urandom % 3 == 0) : ($urandom % 5 == 0);
         rst      = ($urandom % 500 == 0);
         tick();
         exp_oh = m_vld ? (NQ'(1) << m_sel) : NQ'(0);
         checks++; if (grant_vld !== m_vld) begin errors++; $display("FAIL rnd_vld@%0d: got %0d expected %0d", c, grant_vld, m_vld); end
         checks++; if (busy !== (m_phase != 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %0d expected %0d", c, busy, m_phase != 0); end
         checks++; if (grant_onehot !== exp_oh) begin errors++; $display("FAIL rnd_onehot@%0d: got %h expected %h", c, grant_onehot, exp_oh); end
         if (m_vld) begin
            checks++; if (grant_sel !== WW'(m_sel)) begin errors++; $display("FAIL rnd_sel@%0d: got %0d expected %0d", c, grant_sel, m_sel); end
         end
      end
      rst = 1'b0; pkt_done = 1'b0; ready = 1'b0;
   endtask

   initial begin
      m_phase = 0; m_vld = 1'b0; m_sel = 0; m_ptr = 0;
      for (int q = 0; q < NQ; q++) m_credit[q] = 0;
      test_reset();
      test_strict();
      test_wrr_ratio();
      test_zero_weights();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prio_dispatch_scheduler.md
Name: prio_dispatch_scheduler

Overview:
Per-output-port scheduler for the shared-cache switch read side. It decides which of PRIORITY per-priority packet queues for one output port may drain next into rd_sop/rd_eop/rd_vld. It implements the dispatch_sel policy: 0 = strict priority, 1 = weighted round robin using wrr_wieght_in. Decisions are packet-granular: a grant is held from decision until the granted packet's eop is accepted.

Parameters:
PRIORITY, 8, number of priority queues per output port (power of 2, >=2)
WIDTH_PRIORITY, $clog2(PRIORITY), width of a queue index
WIDTH_WIEGHT, $clog2(PRIORITY), width of one WRR weight

Ports:
clk  input  1  system clock (external_clk domain, 250 MHz)
rst  input  1  synchronous, active-high reset
dispatch_sel  input  1  0 = strict priority, 1 = WRR
wrr_wieght_in  input  PRIORITY*WIDTH_WIEGHT  weight of queue q at bits [(q+1)*WIDTH_WIEGHT-1 : q*WIDTH_WIEGHT]
queue_nempty  input  PRIORITY  queue q holds at least one complete packet
ready  input  1  downstream port ready; no new grant is issued while low
pkt_done  input  1  1-cycle pulse: eop of the granted packet accepted by the read datapath
grant_vld  output  1  a grant is active
grant_sel  output  WIDTH_PRIORITY  index of the granted queue
grant_onehot  output  PRIORITY  one-hot of grant_sel; all zero when grant_vld=0
busy  output  1  FSM is not in IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; grant_vld=0; grant_sel=0; grant_onehot=0; busy=0; all credits=0; rr_ptr=0. rst overrides every event, including an active grant mid-packet. Downstream flushing is not this block's job.
- Priority order: queue 0 is highest.
- FSM states: IDLE, REFILL, GRANT.
- IDLE, ready=1, dispatch_sel=0: pick the lowest-index q with queue_nempty[q]. Register grant; next state GRANT. Latency is 1 cycle from the request being visible to grant_vld=1.
- IDLE, ready=1, dispatch_sel=1: eligible[q] = queue_nempty[q] & (credit[q]!=0).
  - Pick the first eligible q scanning upward from rr_ptr, wrapping PRIORITY-1 to 0.
  - On grant: credit[q] decrements by 1 and rr_ptr stays at q, so a queue drains its credits consecutively.
  - When credit[q] reaches 0, rr_ptr advances to q+1 mod PRIORITY.
- IDLE, WRR, no eligible queue, but some nonempty queue has nonzero weight: go to REFILL. No grant that cycle.
- REFILL (1 cycle): credit[q] = weight[q] for all q, sampled from wrr_wieght_in this cycle. Return to IDLE, so a WRR grant after refill costs 2 extra cycles.
- Weight 0 excludes the queue from WRR. If every nonempty queue has weight 0, fall back to the strict-priority pick for that decision. This fallback does not touch credits and does not go to REFILL.
- GRANT: grant_vld=1 and grant_sel/grant_onehot are held stable. On pkt_done=1: grant_vld=0 the next cycle and state=IDLE.
  - Minimum gap between grants is 1 idle cycle.
  - The queue_nempty, ready and dispatch_sel inputs are ignored while in GRANT.
- dispatch_sel and weights are sampled only at decision/refill time. A change mid-packet applies from the next decision. Switching from WRR to strict and back keeps credits and rr_ptr.
- pkt_done outside GRANT is ignored.
- ready=0 in IDLE: hold in IDLE with credits unchanged.
- All queue_nempty=0: stay in IDLE with outputs at 0.
- Credit counters are WIDTH_WIEGHT bits wide; they never underflow (decrement only when nonzero).
- busy = (state != IDLE).

Decomposition:
- Shared package/header (generate_parameter.vh) holds PORT_NUB_TOTAL, PRIORITY, the dispatch_sel encodings (DISPATCH_SP=0, DISPATCH_WRR=1) and the FSM state encoding.
- One sub-module: rr_prio_picker. It is combinational, takes a request vector and a start pointer, and returns found plus index, scanning with wrap. It is instantiated twice: pointer=0 for strict priority, pointer=rr_ptr for WRR.

Test Plan:
1. Strict priority: dispatch_sel=0, queue_nempty=8'b1010_0100, ready=1. Expect grant_sel=2 one cycle later. Pulse pkt_done, then clear bit 2. Expect the next grant to be grant_sel=5.
2. WRR ratio: dispatch_sel=1, weights q0=3, q1=1, others 0, queues 0 and 1 always nonempty, pkt_done 4 cycles after each grant. Over 40 grants the sequence is 0,0,0,1 repeating, with one REFILL cycle per round.
3. All-zero weights: dispatch_sel=1, weights all 0, queue_nempty=8'b0001_1000. Expect grant_sel=3 and no REFILL; busy never shows the REFILL state.
4. Wrap-around: weights all 1, every queue nonempty, rr_ptr=6. Expect grant order 6,7 then REFILL, then 0,1,…
5. Backpressure and ignored inputs: ready=0 with requests pending gives no grant. pkt_done pulses while idle are ignored. Raising ready gives a grant after 1 cycle.
6. Reset mid-packet: rst=1 during GRANT. Next cycle grant_vld=0, busy=0, grant_onehot=0. The first WRR decision after reset goes through REFILL.
